// File: rtl/ascon_img_block_ctrl.sv
// Packs an image byte stream into plaintext blocks, runs one encryption per block,
// and serializes {ciphertext, tag} records onto an output byte stream.
module ascon_img_block_ctrl #(
    parameter int unsigned Y_BITS = 40,
    parameter int unsigned L_BITS = 40,
    parameter int unsigned K_BITS = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [K_BITS-1:0] key,
    input  logic [127:0]      nonce_base,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              enc_start,
    output logic [K_BITS-1:0] enc_key,
    output logic [127:0]      enc_nonce,
    output logic [L_BITS-1:0] enc_ad,
    output logic [Y_BITS-1:0] enc_pt,
    input  logic              enc_ready,
    input  logic [Y_BITS-1:0] enc_ct,
    input  logic [127:0]      enc_tag,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [7:0]        m_data,
    output logic              m_last,
    output logic              m_frame_last,
    output logic              busy
);
    localparam int unsigned NB      = Y_BITS / 8;
    localparam int unsigned SR_BITS = Y_BITS + 128;
    localparam int unsigned OB      = NB + 16;
    localparam int unsigned OW      = $clog2(OB);
    localparam int unsigned BW      = L_BITS - 8;

    typedef enum logic [2:0] {IDLE, FILL, LAUNCH, WAIT, DRAIN} state_t;

    state_t             state;
    logic [7:0]         cnt;
    logic [BW-1:0]      blk_idx;
    logic               last_blk;
    logic [SR_BITS-1:0] sr;
    logic [OW-1:0]      ocnt;
    logic               out_end;

    assign out_end      = (ocnt == OW'(OB - 1));
    assign s_ready      = (state == FILL);
    assign m_valid      = (state == DRAIN);
    assign m_data       = sr[SR_BITS-1 -: 8];
    assign m_last       = m_valid && out_end;
    assign m_frame_last = m_last && last_blk;
    assign busy         = (state != IDLE);
    // The release pulse must coincide with the first enc_ready cycle, so it is decoded, not registered.
    assign enc_start    = (state == LAUNCH) || ((state == WAIT) && enc_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            blk_idx   <= '0;
            last_blk  <= 1'b0;
            sr        <= '0;
            ocnt      <= '0;
            enc_key   <= '0;
            enc_nonce <= '0;
            enc_ad    <= '0;
            enc_pt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        enc_key   <= key;
                        enc_nonce <= nonce_base;
                        blk_idx   <= '0;
                        cnt       <= '0;
                        enc_pt    <= '0;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (s_valid) begin
                        for (int unsigned i = 0; i < NB; i++) begin
                            if (32'(cnt) == i) enc_pt[Y_BITS-1-8*i -: 8] <= s_data;
                        end
                        cnt <= cnt + 8'd1;
                        if ((32'(cnt) == NB - 1) || s_last) begin
                            enc_ad   <= {blk_idx, cnt + 8'd1};
                            last_blk <= s_last;
                            state    <= LAUNCH;
                        end
                    end
                end
                LAUNCH: state <= WAIT;
                WAIT: begin
                    if (enc_ready) begin
                        sr    <= {enc_ct, enc_tag};
                        ocnt  <= '0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (m_ready) begin
                        sr   <= {sr[SR_BITS-9:0], 8'h00};
                        ocnt <= ocnt + OW'(1);
                        if (out_end) begin
                            ocnt <= '0;
                            if (last_blk) begin
                                state <= IDLE;
                            end else begin
                                // Nonce tracks nonce_base + blk_idx incrementally, wrapping at 2^128.
                                blk_idx   <= blk_idx + BW'(1);
                                enc_nonce <= enc_nonce + 128'd1;
                                cnt       <= '0;
                                enc_pt    <= '0;
                                state     <= FILL;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ascon_img_block_ctrl.sv
// Directed bench for ascon_img_block_ctrl with a behavioural stand-in for the encryption core.
`timescale 1ns/1ps
module tb_ascon_img_block_ctrl;
    localparam int unsigned Y_BITS = 40;
    localparam int unsigned L_BITS = 40;
    localparam int unsigned K_BITS = 128;
    localparam int unsigned NB     = 5;
    localparam int unsigned OB     = 21;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         frame_start = 1'b0;
    logic [127:0] key = '0;
    logic [127:0] nonce_base = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [7:0]   s_data = '0;
    logic         s_last = 1'b0;
    logic         enc_start;
    logic [127:0] enc_key;
    logic [127:0] enc_nonce;
    logic [39:0]  enc_ad;
    logic [39:0]  enc_pt;
    logic         enc_ready = 1'b0;
    logic [39:0]  enc_ct = '0;
    logic [127:0] enc_tag = '0;
    logic         m_valid;
    logic         m_ready = 1'b1;
    logic [7:0]   m_data;
    logic         m_last;
    logic         m_frame_last;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ascon_img_block_ctrl #(.Y_BITS(Y_BITS), .L_BITS(L_BITS), .K_BITS(K_BITS)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .key(key), .nonce_base(nonce_base),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .enc_start(enc_start), .enc_key(enc_key), .enc_nonce(enc_nonce), .enc_ad(enc_ad),
        .enc_pt(enc_pt), .enc_ready(enc_ready), .enc_ct(enc_ct), .enc_tag(enc_tag),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .m_frame_last(m_frame_last), .busy(busy)
    );

    function automatic logic [39:0] f_ct(input logic [127:0] k, input logic [127:0] n,
                                         input logic [39:0] ad, input logic [39:0] pt);
        return pt ^ k[39:0] ^ n[47:8] ^ {ad[7:0], ad[39:8]};
    endfunction

    function automatic logic [127:0] f_tag(input logic [127:0] k, input logic [127:0] n,
                                           input logic [39:0] ad, input logic [39:0] pt);
        return {k[63:0], n[127:64]} ^ {n[63:0], k[127:64]} ^ {pt, ad, 48'h5A5A_0000_A5A5};
    endfunction

    // Core stand-in: start latches inputs, result after core_lat cycles, enc_start while done releases.
    int           core_lat = 3;
    int           core_cnt = 0;
    logic         core_busy = 1'b0;
    logic [39:0]  c_pt, c_ad;
    logic [127:0] c_nonce, c_key;
    always @(posedge clk) begin
        if (rst) begin
            core_busy <= 1'b0;
            enc_ready <= 1'b0;
            core_cnt  <= 0;
        end else if (!core_busy && !enc_ready && enc_start) begin
            core_busy <= 1'b1;
            core_cnt  <= core_lat;
            c_pt      <= enc_pt;
            c_ad      <= enc_ad;
            c_nonce   <= enc_nonce;
            c_key     <= enc_key;
        end else if (core_busy) begin
            if (core_cnt <= 1) begin
                core_busy <= 1'b0;
                enc_ready <= 1'b1;
                enc_ct    <= f_ct(c_key, c_nonce, c_ad, c_pt);
                enc_tag   <= f_tag(c_key, c_nonce, c_ad, c_pt);
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end else if (enc_ready && enc_start) begin
            enc_ready <= 1'b0;
        end
    end

    typedef struct packed {
        logic [127:0] k;
        logic [127:0] n;
        logic [39:0]  ad;
        logic [39:0]  pt;
    } lr_t;

    logic [9:0] out_q[$];
    logic [9:0] exp_out[$];
    lr_t        launch_q[$];
    lr_t        exp_launch[$];
    logic [7:0] tx_q[$];
    int         release_n = 0;
    int         stall_bad = 0;
    int         sready_bad = 0;
    bit         mr_rand = 1'b0;

    initial begin
        logic       pv = 1'b0;
        logic       pr = 1'b0;
        logic [9:0] prev = '0;
        forever begin
            @(negedge clk);
            if (m_valid && m_ready) out_q.push_back({m_data, m_last, m_frame_last});
            if (enc_start && !enc_ready) launch_q.push_back('{enc_key, enc_nonce, enc_ad, enc_pt});
            if (enc_start && enc_ready) release_n++;
            if (pv && !pr && m_valid && ({m_data, m_last, m_frame_last} != prev)) stall_bad++;
            if (m_valid && s_ready) sready_bad++;
            pv   = m_valid;
            pr   = m_ready;
            prev = {m_data, m_last, m_frame_last};
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = mr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time=%0t required=finish", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        out_q.delete();
        launch_q.delete();
        release_n  = 0;
        stall_bad  = 0;
        sready_bad = 0;
    endtask

    task automatic start_frame(input logic [127:0] k, input logic [127:0] n);
        key         = k;
        nonce_base  = n;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n = 0;
        while (!s_ready && n < 300) begin
            tick();
            n++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout s_ready=%0b required=1", s_ready);
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_timeout busy=%0b required=0", tag, busy);
        end
        tick();
    endtask

    task automatic send_all();
        foreach (tx_q[i]) send_byte(tx_q[i], i == tx_q.size() - 1);
    endtask

    // Reference streams derived from the byte list alone.
    task automatic build_exp(input logic [127:0] k, input logic [127:0] base);
        int nblk;
        exp_out.delete();
        exp_launch.delete();
        nblk = (tx_q.size() + NB - 1) / NB;
        for (int b = 0; b < nblk; b++) begin
            logic [39:0]  pt, ad;
            logic [127:0] nn;
            logic [167:0] rec;
            int           nb;
            pt = '0;
            nb = 0;
            nn = base + 128'(b);
            for (int j = 0; j < NB; j++) begin
                if (b * NB + j < tx_q.size()) begin
                    pt[39-8*j -: 8] = tx_q[b*NB+j];
                    nb++;
                end
            end
            ad = {32'(b), 8'(nb)};
            exp_launch.push_back('{k, nn, ad, pt});
            rec = {f_ct(k, nn, ad, pt), f_tag(k, nn, ad, pt)};
            for (int j = 0; j < OB; j++)
                exp_out.push_back({rec[167-8*j -: 8], j == OB - 1, (j == OB - 1) && (b == nblk - 1)});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if ({s_ready, enc_start, m_valid, m_data, m_last, m_frame_last, busy} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b required=0", {s_ready, enc_start, m_valid, m_data, m_last, m_frame_last, busy});
        end
        checks++;
        if ({enc_key, enc_nonce, enc_ad, enc_pt} !== '0) begin
            errors++;
            $display("FAIL reset_enc got=%h/%h/%h/%h required=0", enc_key, enc_nonce, enc_ad, enc_pt);
        end
        tick();
    endtask

    task automatic test_single();
        logic [127:0] k = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
        int n = 0;
        clear_logs();
        tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        start_frame(k, '0);
        send_all();
        checks++;
        if (enc_start !== 1'b1) begin errors++; $display("FAIL single_launch enc_start=%0b required=1", enc_start); end
        checks++;
        if ({enc_pt, enc_ad, enc_nonce} !== {40'h0102030405, 40'h0000000005, 128'h0}) begin
            errors++;
            $display("FAIL single_inputs got pt=%h ad=%h nonce=%h required 0102030405/0000000005/0", enc_pt, enc_ad, enc_nonce);
        end
        tick();
        checks++;
        if (enc_start !== 1'b0) begin errors++; $display("FAIL single_launch_width enc_start=%0b required=0", enc_start); end
        while (!enc_ready && n < 100) begin tick(); n++; end
        checks++;
        if ({enc_ready, enc_start, m_valid} !== 3'b110) begin
            errors++;
            $display("FAIL single_capture ready/start/m_valid=%b required=110", {enc_ready, enc_start, m_valid});
        end
        tick();
        checks++;
        if ({enc_start, m_valid} !== 2'b01) begin
            errors++;
            $display("FAIL single_drain_start start/m_valid=%b required=01", {enc_start, m_valid});
        end
        wait_idle("single");
        build_exp(k, '0);
        checks++;
        if (out_q.size() !== 21 || launch_q.size() !== 1 || release_n !== 1) begin
            errors++;
            $display("FAIL single_counts bytes=%0d launches=%0d releases=%0d required 21/1/1", out_q.size(), launch_q.size(), release_n);
        end
        for (int i = 0; i < out_q.size() && i < exp_out.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_out[i]) begin errors++; $display("FAIL single_byte%0d got=%h required=%h", i, out_q[i], exp_out[i]); end
        end
    endtask

    task automatic test_short();
        logic [127:0] k = 128'hdeadbeef_00112233_44556677_8899aabb;
        logic [127:0] b = 128'h12345678_9abcdef0_0fedcba9_87654321;
        clear_logs();
        tx_q = '{8'hAA, 8'hBB, 8'hCC};
        start_frame(k, b);
        send_all();
        wait_idle("short");
        build_exp(k, b);
        checks++;
        if (launch_q.size() !== 1 || out_q.size() !== 21) begin
            errors++;
            $display("FAIL short_counts launches=%0d bytes=%0d required 1/21", launch_q.size(), out_q.size());
        end else begin
            checks++;
            if (launch_q[0].pt !== 40'hAABBCC0000 || launch_q[0].ad[7:0] !== 8'h03) begin
                errors++;
                $display("FAIL short_block pt=%h ad=%h required AABBCC0000/..03", launch_q[0].pt, launch_q[0].ad);
            end
            for (int i = 0; i < 21; i++) begin
                checks++;
                if (out_q[i] !== exp_out[i]) begin errors++; $display("FAIL short_byte%0d got=%h required=%h", i, out_q[i], exp_out[i]); end
            end
        end
    endtask

    task automatic test_multi();
        logic [127:0] k = 128'h00010203_04050607_08090a0b_0c0d0e0f;
        logic [127:0] b = 128'h00000000_00000000_00000000_000000B3;
        int nl = 0;
        int nfl = 0;
        clear_logs();
        tx_q.delete();
        for (int i = 0; i < 12; i++) tx_q.push_back(8'(8'h10 + i));
        start_frame(k, b);
        key = ~k;
        nonce_base = '1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        send_all();
        wait_idle("multi");
        build_exp(k, b);
        checks++;
        if (launch_q.size() !== 3 || out_q.size() !== 63) begin
            errors++;
            $display("FAIL multi_counts launches=%0d bytes=%0d required 3/63", launch_q.size(), out_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (launch_q[i] !== exp_launch[i]) begin
                    errors++;
                    $display("FAIL multi_launch%0d key=%h nonce=%h ad=%h pt=%h required nonce=%h ad=%h pt=%h",
                             i, launch_q[i].k, launch_q[i].n, launch_q[i].ad, launch_q[i].pt,
                             exp_launch[i].n, exp_launch[i].ad, exp_launch[i].pt);
                end
            end
            checks++;
            if (launch_q[2].ad !== 40'h0000000202 || launch_q[2].n !== 128'hB5) begin
                errors++;
                $display("FAIL multi_last_block ad=%h nonce=%h required 0000000202/b5", launch_q[2].ad, launch_q[2].n);
            end
            for (int i = 0; i < 63; i++) begin
                if (out_q[i][1]) nl++;
                if (out_q[i][0]) nfl++;
                checks++;
                if (out_q[i] !== exp_out[i]) begin errors++; $display("FAIL multi_byte%0d got=%h required=%h", i, out_q[i], exp_out[i]); end
            end
            checks++;
            if (nl !== 3 || nfl !== 1 || out_q[62][0] !== 1'b1) begin
                errors++;
                $display("FAIL multi_markers m_last=%0d m_frame_last=%0d required 3/1 on final byte", nl, nfl);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] k = 128'hcafef00d_5555aaaa_12121212_fedcba98;
        logic [127:0] b = 128'h00000000_00000000_00000001_00000000;
        clear_logs();
        tx_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
        mr_rand = 1'b1;
        start_frame(k, b);
        send_all();
        wait_idle("bp");
        mr_rand = 1'b0;
        tick();
        build_exp(k, b);
        checks++;
        if (out_q.size() !== 42) begin
            errors++;
            $display("FAIL bp_count bytes=%0d required=42", out_q.size());
        end
        for (int i = 0; i < out_q.size() && i < exp_out.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_out[i]) begin errors++; $display("FAIL bp_byte%0d got=%h required=%h", i, out_q[i], exp_out[i]); end
        end
        checks++;
        if (stall_bad !== 0 || sready_bad !== 0) begin
            errors++;
            $display("FAIL bp_stability unstable_stalls=%0d s_ready_in_drain=%0d required 0/0", stall_bad, sready_bad);
        end
    endtask

    task automatic test_nonce_wrap();
        logic [127:0] k = 128'h11111111_22222222_33333333_44444444;
        clear_logs();
        tx_q = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6};
        start_frame(k, '1);
        send_all();
        wait_idle("wrap");
        build_exp(k, '1);
        checks++;
        if (launch_q.size() !== 2 || out_q.size() !== 42) begin
            errors++;
            $display("FAIL wrap_counts launches=%0d bytes=%0d required 2/42", launch_q.size(), out_q.size());
        end else begin
            checks++;
            if (launch_q[0].n !== {128{1'b1}} || launch_q[1].n !== 128'h0) begin
                errors++;
                $display("FAIL wrap_nonce n0=%h n1=%h required ff..ff/0", launch_q[0].n, launch_q[1].n);
            end
            for (int i = 0; i < 42; i++) begin
                checks++;
                if (out_q[i] !== exp_out[i]) begin errors++; $display("FAIL wrap_byte%0d got=%h required=%h", i, out_q[i], exp_out[i]); end
            end
        end
    endtask

    task automatic test_reset_wait();
        logic [127:0] k = 128'h99999999_88888888_77777777_66666666;
        logic [127:0] b = 128'h00000000_00000000_00000000_00000040;
        clear_logs();
        core_lat = 8;
        tx_q = '{8'h51, 8'h52, 8'h53};
        start_frame(k, b);
        send_all();
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({s_ready, enc_start, m_valid, m_data, m_last, m_frame_last, busy} !== '0 ||
            {enc_key, enc_nonce, enc_ad, enc_pt} !== '0) begin
            errors++;
            $display("FAIL rstwait_outputs ctrl=%b key=%h nonce=%h ad=%h pt=%h required all 0",
                     {s_ready, enc_start, m_valid, m_data, m_last, m_frame_last, busy}, enc_key, enc_nonce, enc_ad, enc_pt);
        end
        rst = 1'b0;
        core_lat = 3;
        tick();
        clear_logs();
        tx_q = '{8'h61, 8'h62, 8'h63, 8'h64};
        start_frame(k, b);
        send_all();
        wait_idle("rstwait");
        build_exp(k, b);
        checks++;
        if (out_q.size() !== 21 || launch_q.size() !== 1) begin
            errors++;
            $display("FAIL rstwait_counts bytes=%0d launches=%0d required 21/1", out_q.size(), launch_q.size());
        end
        for (int i = 0; i < out_q.size() && i < exp_out.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_out[i]) begin errors++; $display("FAIL rstwait_byte%0d got=%h required=%h", i, out_q[i], exp_out[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_short();
        test_multi();
        test_backpressure();
        test_nonce_wrap();
        test_reset_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ascon_img_block_ctrl.md
# ascon_img_block_ctrl

Byte-stream front end and back end for the Ascon encryption core used in the image datapath. It accepts image bytes on a valid/ready stream and packs them into plaintext blocks. For each block it drives one encryption run with a per-block nonce and associated data, then captures the ciphertext and tag and serializes them onto an output byte stream. It sits between the pixel source and the output sink, and instantiates no core itself: its enc_* ports connect directly to the encryption core's ports.

## Interface
Parameters:
- Y_BITS, 40: plaintext block width in bits; a multiple of 8. NB = Y_BITS/8 bytes per block.
- L_BITS, 40: associated-data width in bits; must be at least 16.
- K_BITS, 128: key width in bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high (shared with the core)
- frame_start  in  1  pulse; sampled only in IDLE
- key  in  K_BITS  latched on frame_start
- nonce_base  in  128  latched on frame_start
- s_valid / s_ready  in / out  1  input byte handshake
- s_data  in  8  image byte
- s_last  in  1  last byte of the frame
- enc_start  out  1  core start/release pulse
- enc_key  out  K_BITS  latched key
- enc_nonce  out  128  per-block nonce
- enc_ad  out  L_BITS  associated data {blk_idx[L_BITS-9:0], nbytes[7:0]}
- enc_pt  out  Y_BITS  packed plaintext
- enc_ready  in  1  core done flag; ct/tag valid only while high
- enc_ct  in  Y_BITS  ciphertext
- enc_tag  in  128  tag
- m_valid / m_ready  out / in  1  output byte handshake
- m_data  out  8  output byte
- m_last  out  1  last byte of a block record
- m_frame_last  out  1  last byte of the frame
- busy  out  1  high whenever the state is not IDLE

## Operation
States: IDLE, FILL, LAUNCH, WAIT, DRAIN.

- **IDLE:** s_ready=0. On frame_start:
  - latch key and nonce_base;
  - clear blk_idx and the byte count;
  - go to FILL.
- **FILL:** s_ready=1. Each accepted byte (s_valid&&s_ready) is written into enc_pt, MSB first: byte i goes to enc_pt[Y_BITS-1-8i -: 8].
  - The buffer is zeroed on entry to FILL, so unfilled bytes of a short block are 0x00.
  - When the accepted byte is byte NB-1, or carries s_last, record nbytes = count+1 and last_blk = s_last, then go to LAUNCH.
- **LAUNCH:** enc_start=1 for exactly one cycle, then go to WAIT.
- **WAIT:** enc_start=0 until enc_ready=1. In the first cycle where enc_ready=1:
  - load the output shift register with {enc_ct, enc_tag} (NB+16 bytes);
  - drive enc_start=1 for that one cycle, which returns the core to its idle state;
  - go to DRAIN.
- **DRAIN:** m_valid=1 and m_data = top byte of the shift register. The register shifts on m_valid&&m_ready.
  - m_last is asserted on byte NB+15.
  - m_frame_last is asserted on that same byte when last_blk=1.
  - After byte NB+15 is accepted: if last_blk, go to IDLE; otherwise increment blk_idx and go to FILL.
- **Per-block values:**
  - enc_nonce = nonce_base + blk_idx, modulo 2^128 (wraps).
  - blk_idx is L_BITS-8 bits wide and wraps.
- **Input stability:** enc_key, enc_nonce, enc_ad and enc_pt change only in FILL and at frame_start. They are held stable from LAUNCH through the capture cycle.
- **Boundary cases:**
  - frame_start outside IDLE is ignored.
  - s_last on byte NB-1 closes the frame normally.
  - The s_data/s_last inputs are ignored outside FILL.
  - enc_ready outside WAIT is ignored.

## Timing
- **Reset values:** state=IDLE; s_ready=0, enc_start=0, m_valid=0, m_data=0, m_last=0, m_frame_last=0, busy=0; enc_key=0, enc_nonce=0, enc_ad=0, enc_pt=0.
- **Reset mid-operation:** returns to IDLE on the next edge. Partial data is discarded; the core resets on the same edge.
- **Launch:** the final byte of a block is accepted at cycle T; enc_start=1 at T+1; WAIT begins at T+2.
- **Capture:** enc_ready is first seen high at cycle W; the release pulse is at W; m_valid=1 from W+1.
- **Output rate:** one byte per cycle when m_ready is held high. m_data, m_last and m_frame_last are held stable while m_valid=1 and m_ready=0.
- **Block turnaround:** after the final DRAIN byte is accepted, FILL begins (s_ready=1) on the next cycle.

## Test plan
- **Single full block:** frame_start with nonce_base=0, then bytes 01..05 with s_last on the fifth byte.
  - One enc_start pulse with enc_pt=0x0102030405, enc_ad=0x0000000005, enc_nonce=0.
  - Release pulse in the enc_ready cycle.
  - 21 output bytes; m_last and m_frame_last both high on byte 21.
- **Short block:** bytes AA,BB,CC with s_last on CC.
  - enc_pt=0xAABBCC0000, enc_ad low byte = 0x03.
  - Output ct bytes match the core model; 21 bytes out.
- **Multi-block frame:** 12 bytes sent.
  - Three runs with nonces base, base+1, base+2 and AD blk_idx 0,1,2; last nbytes=2.
  - m_last is asserted three times; m_frame_last only on the final byte.
- **Output backpressure:** m_ready toggled randomly.
  - No byte lost or duplicated.
  - m_data is stable during stalls.
  - s_ready stays 0 until the drain completes.
- **Nonce wrap:** nonce_base = 2^128-1 with a 2-block frame. Block 1 nonce = 0.
- **Reset in WAIT:** rst asserted for one cycle.
  - All outputs return to reset values on the next cycle.
  - A new frame_start completes a correct block afterwards.
